// File: rtl/maze_grid_renderer_pkg.sv
// Shared definitions for the maze grid renderer: cell-byte layout, packet fields,
// opcodes, FSM states and the RGB332 palette.
package maze_grid_renderer_pkg;

    localparam int CELL_ROBOT    = 1;
    localparam int CELL_EXPLORED = 2;
    localparam int CELL_TREASURE = 3;
    localparam int CELL_WALL_N   = 4;
    localparam int CELL_WALL_E   = 5;
    localparam int CELL_WALL_S   = 6;
    localparam int CELL_WALL_W   = 7;

    localparam int PKT_COL_LO = 13;
    localparam int PKT_ROW_LO = 11;
    localparam int PKT_OP_LO  = 8;

    typedef enum logic [2:0] {
        OP_WRITE = 3'd0,
        OP_CLEAR = 3'd1,
        OP_MOVE  = 3'd2
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MOVE
    } state_t;

    localparam logic [7:0] COLOR_BLACK   = 8'h00;
    localparam logic [7:0] COLOR_WALL    = 8'b000_000_11;
    localparam logic [7:0] COLOR_ROBOT   = 8'b111_100_00;
    localparam logic [7:0] COLOR_TREASURE= 8'b111_000_11;
    localparam logic [7:0] COLOR_WHITE   = 8'hFF;
    localparam logic [7:0] COLOR_GREY    = 8'b010_010_01;

    // In-grid colour priority: wall, robot (blinking), treasure, explored, empty.
    function automatic logic [7:0] cell_colour(input logic wall_hit, input logic robot,
                                               input logic treasure, input logic explored,
                                               input logic blink_phase);
        logic [7:0] c;
        c = COLOR_GREY;
        if (wall_hit)
            c = COLOR_WALL;
        else if (robot)
            c = blink_phase ? COLOR_WHITE : COLOR_ROBOT;
        else if (treasure)
            c = COLOR_TREASURE;
        else if (explored)
            c = COLOR_WHITE;
        return c;
    endfunction

endpackage

// File: rtl/maze_grid_renderer_blink.sv
// Frame detector and blink-phase generator: a frame starts when the pixel row
// returns from nonzero to zero; the phase toggles every BLINK_FRAMES frames.
module maze_blink_timer #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [9:0] pixel_y,
    output logic       phase
);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0]       y_prev_reg;
    logic [CNT_W-1:0] frame_cnt_reg;
    logic             phase_reg;
    logic             new_frame;

    assign new_frame = (y_prev_reg != 10'd0) && (pixel_y == 10'd0);
    assign phase     = phase_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            y_prev_reg    <= '0;
            frame_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else begin
            y_prev_reg <= pixel_y;
            if (new_frame) begin
                if (frame_cnt_reg == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt_reg <= '0;
                    phase_reg     <= ~phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/maze_grid_renderer.sv
// Maze cell store written by radio packets, plus a two-stage pixel colouriser
// that maps VGA coordinates onto cell fill, wall, treasure and robot colours.
module maze_grid_renderer
    import maze_grid_renderer_pkg::*;
#(
    parameter int GRID_ROWS    = 4,
    parameter int GRID_COLS    = 5,
    parameter int CELL_PX      = 100,
    parameter int WALL_PX      = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [9:0]  PIXEL_X,
    input  logic [9:0]  PIXEL_Y,
    input  logic [15:0] DATA_IN,
    input  logic        DATA_VAL,
    output logic        BUSY,
    output logic        WR_DROP,
    output logic [7:0]  COLOR_OUT
);
    localparam int N_CELLS = GRID_ROWS * GRID_COLS;
    localparam int ADDR_W  = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

    logic [7:0] mem [N_CELLS];

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] idx_reg, idx_next;
    logic [ADDR_W-1:0] target_reg, target_next;
    logic              drop_reg, drop_next;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    logic [2:0]        pkt_col;
    logic [1:0]        pkt_row;
    opcode_t           pkt_op;
    logic              pkt_in_range;
    logic [ADDR_W-1:0] pkt_addr;
    logic              sweep_last;

    assign pkt_col      = DATA_IN[PKT_COL_LO +: 3];
    assign pkt_row      = DATA_IN[PKT_ROW_LO +: 2];
    assign pkt_op       = opcode_t'(DATA_IN[PKT_OP_LO +: 3]);
    assign pkt_in_range = (int'(pkt_row) < GRID_ROWS) && (int'(pkt_col) < GRID_COLS);
    assign pkt_addr     = ADDR_W'(int'(pkt_row) * GRID_COLS + int'(pkt_col));
    assign sweep_last   = (idx_reg == ADDR_W'(N_CELLS - 1));

    assign BUSY    = (state_reg != ST_IDLE);
    assign WR_DROP = drop_reg;

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        target_next = target_reg;
        drop_next   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = idx_reg;
        mem_wdata   = 8'h00;
        case (state_reg)
            ST_CLEAR, ST_MOVE: begin
                mem_we = 1'b1;
                // MOVE rewrites each cell with the robot bit set only on the target,
                // so the final grid matches clear-all-then-set with one write port.
                if (state_reg == ST_MOVE) begin
                    mem_wdata             = mem[idx_reg];
                    mem_wdata[CELL_ROBOT] = (idx_reg == target_reg);
                end
                drop_next = DATA_VAL;
                if (sweep_last) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                if (DATA_VAL) begin
                    if (!pkt_in_range) begin
                        drop_next = 1'b1;
                    end else begin
                        case (pkt_op)
                            OP_WRITE: begin
                                mem_we    = 1'b1;
                                mem_waddr = pkt_addr;
                                mem_wdata = DATA_IN[7:0];
                            end
                            OP_CLEAR: begin
                                state_next = ST_CLEAR;
                                idx_next   = '0;
                            end
                            OP_MOVE: begin
                                state_next  = ST_MOVE;
                                idx_next    = '0;
                                target_next = pkt_addr;
                            end
                            default: drop_next = 1'b1;
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_CLEAR;
            idx_reg    <= '0;
            target_reg <= '0;
            drop_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            target_reg <= target_next;
            drop_reg   <= drop_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we && !RESET)
            mem[mem_waddr] <= mem_wdata;
    end

    logic [2:0] s1_col_reg;
    logic [1:0] s1_row_reg;
    logic [9:0] s1_offx_reg, s1_offy_reg;
    logic       s1_oog_reg;
    logic       blink_phase;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_col_reg  <= '0;
            s1_row_reg  <= '0;
            s1_offx_reg <= '0;
            s1_offy_reg <= '0;
            s1_oog_reg  <= 1'b1;
        end else begin
            s1_col_reg  <= 3'(PIXEL_X / 10'(CELL_PX));
            s1_row_reg  <= 2'(PIXEL_Y / 10'(CELL_PX));
            s1_offx_reg <= PIXEL_X % 10'(CELL_PX);
            s1_offy_reg <= PIXEL_Y % 10'(CELL_PX);
            s1_oog_reg  <= (int'(PIXEL_X) >= GRID_COLS * CELL_PX) ||
                           (int'(PIXEL_Y) >= GRID_ROWS * CELL_PX);
        end
    end

    logic [ADDR_W-1:0] rd_addr;
    logic              wall_hit;

    assign rd_addr  = s1_oog_reg ? '0 : ADDR_W'(int'(s1_row_reg) * GRID_COLS + int'(s1_col_reg));
    assign wall_hit = (mem[rd_addr][CELL_WALL_N] && (s1_offy_reg <  10'(WALL_PX))) ||
                      (mem[rd_addr][CELL_WALL_W] && (s1_offx_reg <  10'(WALL_PX))) ||
                      (mem[rd_addr][CELL_WALL_S] && (s1_offy_reg >= 10'(CELL_PX - WALL_PX))) ||
                      (mem[rd_addr][CELL_WALL_E] && (s1_offx_reg >= 10'(CELL_PX - WALL_PX)));

    always_ff @(posedge CLK) begin
        if (RESET)
            COLOR_OUT <= COLOR_BLACK;
        else if (s1_oog_reg)
            COLOR_OUT <= COLOR_BLACK;
        else
            COLOR_OUT <= cell_colour(wall_hit, mem[rd_addr][CELL_ROBOT],
                                     mem[rd_addr][CELL_TREASURE],
                                     mem[rd_addr][CELL_EXPLORED], blink_phase);
    end

    maze_blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk     (CLK),
        .srst    (RESET),
        .pixel_y (PIXEL_Y),
        .phase   (blink_phase)
    );

endmodule

// File: tb/tb_maze_grid_renderer.sv
// Directed bench for maze_grid_renderer: packets, wall/robot/treasure colours,
// blink timing, packet drops and clear sweep restart on reset.
module tb_maze_grid_renderer;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [9:0]  PIXEL_X;
    logic [9:0]  PIXEL_Y;
    logic [15:0] DATA_IN;
    logic        DATA_VAL;
    logic        BUSY;
    logic        WR_DROP;
    logic [7:0]  COLOR_OUT;

    int tests_run = 0;
    int failures  = 0;
    int busy_cycles;

    localparam logic [7:0] GREY    = 8'h49;
    localparam logic [7:0] BLUE    = 8'h03;
    localparam logic [7:0] YELLOW  = 8'hF0;
    localparam logic [7:0] MAGENTA = 8'hE3;
    localparam logic [7:0] WHITE   = 8'hFF;

    maze_grid_renderer dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .PIXEL_X   (PIXEL_X),
        .PIXEL_Y   (PIXEL_Y),
        .DATA_IN   (DATA_IN),
        .DATA_VAL  (DATA_VAL),
        .BUSY      (BUSY),
        .WR_DROP   (WR_DROP),
        .COLOR_OUT (COLOR_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] exp, input string tag);
        PIXEL_X = 10'(x);
        PIXEL_Y = 10'(y);
        tick();
        tick();
        $display("[TB] pixel (%0d,%0d) colour=%02h", x, y, COLOR_OUT);
        check_eq(tag, 32'(COLOR_OUT), 32'(exp));
    endtask

    task automatic send(input int col, input int row, input int op, input logic [7:0] b,
                        input logic exp_drop, input string tag);
        DATA_IN  = {3'(col), 2'(row), 3'(op), b};
        DATA_VAL = 1'b1;
        tick();
        DATA_VAL = 1'b0;
        $display("[TB] packet col=%0d row=%0d op=%0d byte=%02h drop=%0d", col, row, op, b, WR_DROP);
        check_eq(tag, 32'(WR_DROP), 32'(exp_drop));
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (BUSY && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        RESET    = 1'b1;
        PIXEL_X  = '0;
        PIXEL_Y  = '0;
        DATA_IN  = '0;
        DATA_VAL = 1'b0;
        repeat (3) tick();
        check_eq("rst_busy", 32'(BUSY), 32'd1);
        check_eq("rst_drop", 32'(WR_DROP), 32'd0);
        check_eq("rst_color", 32'(COLOR_OUT), 32'd0);
        RESET = 1'b0;
        wait_idle(busy_cycles);
        $display("[TB] initial sweep busy for %0d cycles", busy_cycles);
        check_eq("init_busy_len", 32'(busy_cycles), 32'd20);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++)
                pix(c * 100 + 50, r * 100 + 50, GREY, "init_grey");
        pix(499, 399, GREY, "last_px_grey");
        pix(500, 50, 8'h00, "oog_x");
        pix(50, 400, 8'h00, "oog_y");

        send(2, 1, 0, 8'h04, 1'b0, "wr_explored");
        pix(250, 150, WHITE, "explored_white");
        pix(150, 150, GREY, "neighbour_grey");

        send(0, 0, 0, 8'h10, 1'b0, "wr_nwall");
        pix(50, 2, BLUE, "n_wall");
        pix(50, 3, BLUE, "n_wall_edge");
        pix(50, 4, GREY, "n_wall_past");
        pix(50, 50, GREY, "n_wall_centre");
        send(0, 0, 0, 8'h90, 1'b0, "wr_nwwall");
        pix(1, 50, BLUE, "w_wall");
        pix(4, 50, GREY, "w_wall_past");
        pix(98, 50, GREY, "no_e_wall");

        send(1, 0, 0, 8'h08, 1'b0, "wr_treasure");
        pix(150, 50, MAGENTA, "treasure");

        send(0, 0, 0, 8'h02, 1'b0, "wr_robot");
        pix(50, 50, YELLOW, "robot_before_move");
        send(4, 3, 2, 8'h55, 1'b0, "move");
        check_eq("move_busy", 32'(BUSY), 32'd1);
        send(1, 1, 0, 8'h04, 1'b1, "drop_in_move");
        wait_idle(busy_cycles);
        check_eq("move_busy_len", 32'(busy_cycles), 32'd19);
        pix(50, 50, GREY, "robot_left");
        pix(450, 350, YELLOW, "robot_arrived");
        pix(250, 150, WHITE, "move_keeps_explored");
        pix(150, 150, GREY, "move_dropped_write");

        send(3, 2, 0, 8'h1A, 1'b0, "wr_prio");
        pix(350, 201, BLUE, "wall_over_robot");
        pix(350, 250, YELLOW, "robot_over_treasure");

        for (int f = 0; f < 29; f++) begin
            PIXEL_Y = 10'd0;
            tick();
            PIXEL_Y = 10'd1;
            tick();
        end
        pix(450, 350, YELLOW, "blink_29_frames");
        PIXEL_Y = 10'd0;
        tick();
        pix(450, 350, WHITE, "blink_30_frames");
        pix(350, 250, WHITE, "blink_second_robot");

        send(5, 3, 0, 8'h04, 1'b1, "drop_col");
        send(0, 3, 5, 8'h04, 1'b1, "drop_opcode");
        tick();
        check_eq("drop_one_cycle", 32'(WR_DROP), 32'd0);
        pix(50, 350, GREY, "drop_no_write");

        send(0, 0, 1, 8'h00, 1'b0, "clear");
        send(0, 0, 0, 8'h04, 1'b1, "drop_busy");
        wait_idle(busy_cycles);
        check_eq("clear_busy_len", 32'(busy_cycles), 32'd19);
        pix(250, 150, GREY, "cleared_explored");
        pix(50, 50, GREY, "cleared_cell0");

        send(2, 1, 0, 8'h04, 1'b0, "rewr_explored");
        send(3, 2, 0, 8'h08, 1'b0, "rewr_treasure");
        pix(350, 250, MAGENTA, "rewr_check");
        send(0, 0, 1, 8'h00, 1'b0, "clear2");
        repeat (5) tick();
        RESET = 1'b1;
        tick();
        check_eq("midrst_busy", 32'(BUSY), 32'd1);
        check_eq("midrst_color", 32'(COLOR_OUT), 32'd0);
        RESET = 1'b0;
        wait_idle(busy_cycles);
        $display("[TB] restarted sweep busy for %0d cycles", busy_cycles);
        check_eq("restart_busy_len", 32'(busy_cycles), 32'd20);
        pix(250, 150, GREY, "restart_grey_a");
        pix(350, 250, GREY, "restart_grey_b");
        pix(450, 350, GREY, "restart_grey_c");

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
